// File: rtl/hram_arb_pkg.sv
// Shared types and constants for the HyperRAM requester arbiter.
package hram_arb_pkg;

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    ISSUE   = 2'd1,
    WAIT_RD = 2'd2,
    GAP     = 2'd3
  } arb_state_t;

  localparam int          N_REQ_MAX = 4;
  localparam logic [31:0] WDOG_FILL = 32'hDEAD_BEEF;

endpackage

// File: rtl/hram_req_arbiter_rr_pick.sv
// rr_pick: combinational round-robin selector. The search starts at the
// requester just after i_ptr and wraps, so the last winner has lowest priority.
module rr_pick
  import hram_arb_pkg::*;
#(
  parameter int N_REQ = 2
) (
  input  logic [N_REQ-1:0] i_req,
  input  logic [1:0]       i_ptr,
  output logic [1:0]       o_idx,
  output logic             o_vld
);

  // Scan from farthest to nearest so the nearest pending requester wins.
  always_comb begin
    o_idx = '0;
    o_vld = 1'b0;
    for (int k = N_REQ; k >= 1; k--) begin
      if (i_req[(int'(i_ptr) + k) % N_REQ]) begin
        o_idx = 2'((int'(i_ptr) + k) % N_REQ);
        o_vld = 1'b1;
      end
    end
  end

endmodule

// File: rtl/hram_req_arbiter.sv
// hram_req_arbiter: serialises N Avalon-MM requesters onto the single s0 port
// of the HyperRAM controller, one transaction at a time, with a forced idle gap
// between transactions. Optional read watchdog: define HRAM_ARB_WDOG_EN.
module hram_req_arbiter
  import hram_arb_pkg::*;
#(
  parameter int N_REQ       = 2,
  parameter int GAP_CYCLES  = 12,
  parameter int WDOG_CYCLES = 1024
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic [N_REQ*32-1:0]  s_address,
  input  logic [N_REQ-1:0]     s_read,
  input  logic [N_REQ-1:0]     s_write,
  input  logic [N_REQ*32-1:0]  s_writedata,
  output logic [N_REQ-1:0]     s_waitrequest,
  output logic [31:0]          s_readdata,
  output logic [N_REQ-1:0]     s_readdatavalid,
  output logic [31:0]          m_address,
  output logic                 m_read,
  output logic                 m_write,
  output logic [31:0]          m_writedata,
  input  logic                 m_waitrequest,
  input  logic [31:0]          m_readdata,
  input  logic                 m_readdatavalid,
  output logic [1:0]           grant_id,
  output logic                 busy,
  output logic                 wdog_err
);

  // One counter width covers both the gap and the watchdog down-counters.
  localparam int CNT_MAX = (GAP_CYCLES > WDOG_CYCLES) ? GAP_CYCLES : WDOG_CYCLES;
  localparam int CNT_W   = $clog2(CNT_MAX + 1);
  localparam int IDX_W   = (N_REQ > 1) ? $clog2(N_REQ) : 1;

  arb_state_t         r_state, w_state_nxt;
  logic [1:0]         r_rr_ptr;
  logic [1:0]         r_grant;
  logic [31:0]        r_m_address, r_m_writedata, r_s_readdata;
  logic               r_m_read, r_m_write, r_busy, r_wdog_err;
  logic [N_REQ-1:0]   r_rdv;
  logic [CNT_W-1:0]   r_gap_cnt;
  logic [N_REQ-1:0]   w_req;
  logic [1:0]         w_pick_idx;
  logic               w_pick_vld;
  logic [IDX_W-1:0]   w_idx;
  logic               w_accept;
  logic               w_enter_gap;
`ifdef HRAM_ARB_WDOG_EN
  logic [CNT_W-1:0]   r_wdog_cnt;
  logic               w_wdog_fire;
`endif

  assign w_req    = s_read | s_write;
  assign w_idx    = w_pick_idx[IDX_W-1:0];
  assign w_accept = (r_state == ISSUE) && !m_waitrequest;

  rr_pick #(.N_REQ(N_REQ)) u_pick (
    .i_req (w_req),
    .i_ptr (r_rr_ptr),
    .o_idx (w_pick_idx),
    .o_vld (w_pick_vld)
  );

`ifdef HRAM_ARB_WDOG_EN
  assign w_wdog_fire = (r_state == WAIT_RD) && !m_readdatavalid && (r_wdog_cnt == '0);
`endif

  // State register.
  always_ff @(posedge clk) begin
    if (rst) r_state <= IDLE;
    else     r_state <= w_state_nxt;
  end

  // Next-state logic.
  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      IDLE:    if (w_pick_vld) w_state_nxt = ISSUE;
      ISSUE:   if (!m_waitrequest) w_state_nxt = r_m_read ? WAIT_RD : GAP;
      WAIT_RD: begin
        if (m_readdatavalid) w_state_nxt = GAP;
`ifdef HRAM_ARB_WDOG_EN
        if (w_wdog_fire)     w_state_nxt = GAP;
`endif
      end
      GAP:     if (r_gap_cnt == '0) w_state_nxt = IDLE;
      default: w_state_nxt = IDLE;
    endcase
  end

  assign w_enter_gap = (r_state != GAP) && (w_state_nxt == GAP);

  // Command capture, response routing, round-robin pointer and gap counter.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_rr_ptr      <= 2'(N_REQ - 1);
      r_grant       <= '0;
      r_m_address   <= '0;
      r_m_writedata <= '0;
      r_m_read      <= 1'b0;
      r_m_write     <= 1'b0;
      r_s_readdata  <= '0;
      r_rdv         <= '0;
      r_busy        <= 1'b0;
      r_gap_cnt     <= '0;
    end else begin
      r_rdv  <= '0;
      r_busy <= (r_state != IDLE);
      if (r_state == IDLE && w_pick_vld) begin
        // Read beats write when a requester raises both; the write stays pending.
        r_m_address   <= s_address[32*w_idx +: 32];
        r_m_writedata <= s_writedata[32*w_idx +: 32];
        r_m_read      <= s_read[w_idx];
        r_m_write     <= !s_read[w_idx];
        r_grant       <= w_pick_idx;
      end
      if (w_accept) begin
        r_m_read  <= 1'b0;
        r_m_write <= 1'b0;
        r_rr_ptr  <= r_grant;
      end
      if (r_state == WAIT_RD && m_readdatavalid) begin
        r_s_readdata            <= m_readdata;
        r_rdv[r_grant[IDX_W-1:0]] <= 1'b1;
      end
`ifdef HRAM_ARB_WDOG_EN
      if (w_wdog_fire) begin
        r_s_readdata              <= WDOG_FILL;
        r_rdv[r_grant[IDX_W-1:0]] <= 1'b1;
      end
`endif
      if (w_enter_gap)          r_gap_cnt <= CNT_W'(GAP_CYCLES - 1);
      else if (r_state == GAP)  r_gap_cnt <= r_gap_cnt - 1'b1;
    end
  end

`ifdef HRAM_ARB_WDOG_EN
  // Read-response watchdog; the error flag is sticky until reset.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_wdog_cnt <= '0;
      r_wdog_err <= 1'b0;
    end else begin
      if (w_accept && r_m_read)    r_wdog_cnt <= CNT_W'(WDOG_CYCLES - 1);
      else if (r_state == WAIT_RD) r_wdog_cnt <= r_wdog_cnt - 1'b1;
      if (w_wdog_fire)             r_wdog_err <= 1'b1;
    end
  end
`else
  assign r_wdog_err = 1'b0;
`endif

  // Only the granted requester sees its stall drop, and only on the accept cycle.
  always_comb begin
    for (int i = 0; i < N_REQ; i++)
      s_waitrequest[i] = !((r_state == ISSUE) && (r_grant == 2'(i)) && !m_waitrequest);
  end

  assign m_address       = r_m_address;
  assign m_writedata     = r_m_writedata;
  assign m_read          = r_m_read;
  assign m_write         = r_m_write;
  assign s_readdata      = r_s_readdata;
  assign s_readdatavalid = r_rdv;
  assign grant_id        = r_grant;
  assign busy            = r_busy;
  assign wdog_err        = r_wdog_err;

endmodule

// File: tb/tb_hram_req_arbiter.sv
// Directed bench for hram_req_arbiter with a read-response scoreboard.
module tb_hram_req_arbiter;
  localparam int N   = 2;
  localparam int GAP = 12;
  localparam int WD  = 1024;

  logic            clk = 1'b0;
  logic            rst;
  logic [N*32-1:0] s_address, s_writedata;
  logic [N-1:0]    s_read, s_write, s_waitrequest, s_readdatavalid;
  logic [31:0]     s_readdata, m_address, m_writedata, m_readdata;
  logic            m_read, m_write, m_waitrequest, m_readdatavalid;
  logic [1:0]      grant_id;
  logic            busy, wdog_err;

  typedef struct { logic [1:0] id; logic [31:0] data; } rsp_t;
  rsp_t sb[$];
  int   n_tests = 0;
  int   n_fail  = 0;

  hram_req_arbiter #(.N_REQ(N), .GAP_CYCLES(GAP), .WDOG_CYCLES(WD)) dut (
    .clk(clk), .rst(rst),
    .s_address(s_address), .s_read(s_read), .s_write(s_write),
    .s_writedata(s_writedata), .s_waitrequest(s_waitrequest),
    .s_readdata(s_readdata), .s_readdatavalid(s_readdatavalid),
    .m_address(m_address), .m_read(m_read), .m_write(m_write),
    .m_writedata(m_writedata), .m_waitrequest(m_waitrequest),
    .m_readdata(m_readdata), .m_readdatavalid(m_readdatavalid),
    .grant_id(grant_id), .busy(busy), .wdog_err(wdog_err)
  );

  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_tests++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  // Wait (bounded) for a command on the master side; returns ticks taken.
  task automatic wait_cmd(input string tag, output int n);
    n = 0;
    while (!(m_read || m_write) && n < 300) begin
      tick();
      n++;
    end
    chk({tag, "_timeout"}, 32'(n >= 300), 32'd0);
  endtask

  // Pop the oldest expected response and compare it with the current outputs.
  task automatic check_rdv(input string tag);
    rsp_t e;
    if (sb.size() == 0) begin
      chk({tag, "_sb_empty"}, 32'd1, 32'd0);
    end else begin
      e = sb.pop_front();
      chk({tag, "_rdv"},  32'(s_readdatavalid), 32'd1 << e.id);
      chk({tag, "_data"}, s_readdata, e.data);
    end
  endtask

  // Controller returns read data for one cycle; response expected next cycle.
  task automatic resp(input string tag, input logic [1:0] id, input logic [31:0] d);
    m_readdatavalid = 1'b1;
    m_readdata      = d;
    sb.push_back('{id, d});
    tick();
    m_readdatavalid = 1'b0;
    check_rdv(tag);
  endtask

  task automatic idle_wait(input int n);
    for (int i = 0; i < n; i++) tick();
  endtask

  task automatic chk_reset_vals(input string tag);
    chk({tag, "_swait"}, 32'(s_waitrequest), 32'h3);
    chk({tag, "_rdv"},   32'(s_readdatavalid), 32'h0);
    chk({tag, "_cmd"},   {30'd0, m_read, m_write}, 32'h0);
    chk({tag, "_addr"},  m_address ^ m_writedata ^ s_readdata, 32'h0);
    chk({tag, "_misc"},  {28'd0, grant_id, busy, wdog_err}, 32'h0);
  endtask

  initial begin
    int n;
    logic [31:0] exp_data;
    rst = 1'b1; s_address = '0; s_writedata = '0; s_read = '0; s_write = '0;
    m_waitrequest = 1'b1; m_readdata = '0; m_readdatavalid = 1'b0;
    idle_wait(3);
    chk_reset_vals("reset");
    rst = 1'b0;
    tick();

    // Single write, controller stalls 3 cycles.
    s_address[31:0] = 32'h0000_0010; s_writedata[31:0] = 32'hA5A5_5A5A; s_write[0] = 1'b1;
    wait_cmd("wr_cmd", n);
    chk("wr_first_latency", 32'(n), 32'd1);
    chk("wr_addr", m_address, 32'h0000_0010);
    chk("wr_data", m_writedata, 32'hA5A5_5A5A);
    for (int k = 0; k < 3; k++) begin
      chk("wr_hold_swait", 32'(s_waitrequest), 32'h3);
      tick();
      chk("wr_hold", {m_write, m_read, m_address[7:0] == 8'h10, m_writedata == 32'hA5A5_5A5A}, 32'b1011);
    end
    m_waitrequest = 1'b0;
    #1 chk("wr_accept_swait", 32'(s_waitrequest), 32'h2);
    s_write[0] = 1'b0;
    tick();
    chk("wr_after_accept", {29'd0, m_write, s_waitrequest}, 32'h3);
    s_writedata[31:0] = 32'h1111_2222; s_write[0] = 1'b1;
    wait_cmd("wr2_cmd", n);
    chk("wr_gap_spacing", 32'(n + 1), 32'(GAP + 2));
    chk("wr2_data", m_writedata, 32'h1111_2222);
    s_write[0] = 1'b0;
    tick();
    idle_wait(GAP + 2);

    // Read routed to requester 1.
    s_address[63:32] = 32'h40; s_read[1] = 1'b1;
    wait_cmd("rd_cmd", n);
    chk("rd_grant", {m_read, m_write, 28'd0, grant_id}, 32'h8000_0001);
    chk("rd_addr", m_address, 32'h40);
    chk("rd_swait", 32'(s_waitrequest), 32'h1);
    s_read[1] = 1'b0;
    tick();
    for (int k = 0; k < 19; k++) tick();
    chk("rd_no_early_rdv", 32'(s_readdatavalid), 32'h0);
    resp("rd_route", 2'd1, 32'h1234_5678);
    tick();
    chk("rd_rdv_single", 32'(s_readdatavalid), 32'h0);
    idle_wait(GAP + 2);

    // Fairness with both requesters holding reads.
    s_address[31:0] = 32'h100; s_address[63:32] = 32'h200; s_read = 2'b11;
    for (int t = 0; t < 6; t++) begin
      wait_cmd("fair_cmd", n);
      chk($sformatf("fair_grant%0d", t), 32'(grant_id), 32'(t % 2));
      chk($sformatf("fair_addr%0d", t), m_address, (t % 2) ? 32'h200 : 32'h100);
      tick();
      tick();
      exp_data = 32'hF000_0000 + 32'(t);
      resp($sformatf("fair_rsp%0d", t), 2'(t % 2), exp_data);
    end
    s_read = '0;
    idle_wait(GAP + 2);

    // Requester 0 raises read and write together: read first, then write.
    s_address[31:0] = 32'h300; s_writedata[31:0] = 32'hCAFE_F00D;
    s_read[0] = 1'b1; s_write[0] = 1'b1;
    wait_cmd("conf_rd", n);
    chk("conf_rd_first", {30'd0, m_read, m_write}, 32'h2);
    s_read[0] = 1'b0;
    tick();
    tick();
    resp("conf_rsp", 2'd0, 32'h0BAD_CAFE);
    wait_cmd("conf_wr", n);
    chk("conf_wr_next", {30'd0, m_read, m_write}, 32'h1);
    chk("conf_wr_data", m_writedata, 32'hCAFE_F00D);
    s_write[0] = 1'b0;
    tick();
    idle_wait(GAP + 2);

    // Reset during WAIT_RD aborts; stray response afterwards is ignored.
    s_address[63:32] = 32'h500; s_read[1] = 1'b1;
    wait_cmd("abort_cmd", n);
    s_read[1] = 1'b0;
    tick();
    idle_wait(3);
    rst = 1'b1;
    tick();
    chk_reset_vals("abort_reset");
    rst = 1'b0;
    tick();
    m_readdatavalid = 1'b1; m_readdata = 32'h5555_AAAA;
    tick();
    m_readdatavalid = 1'b0;
    for (int k = 0; k < 3; k++) begin
      chk("stray_dropped", {29'd0, busy, s_readdatavalid}, 32'h0);
      tick();
    end

    // After reset requester 0 has first priority.
    s_read = 2'b11;
    wait_cmd("ptr_cmd", n);
    chk("ptr_reset_grant", 32'(grant_id), 32'd0);
    s_read = '0;
    tick();
    resp("ptr_rsp", 2'd0, 32'h7777_0000);
    idle_wait(GAP + 2);

`ifdef HRAM_ARB_WDOG_EN
    s_address[31:0] = 32'h600; s_read[0] = 1'b1;
    wait_cmd("wd_cmd", n);
    s_read[0] = 1'b0;
    tick();
    n = 0;
    while (s_readdatavalid == '0 && n < WD + 50) begin
      tick();
      n++;
    end
    chk("wd_timeout", 32'(n >= WD + 50), 32'd0);
    sb.push_back('{2'd0, 32'hDEAD_BEEF});
    check_rdv("wd_fill");
    chk("wd_err", 32'(wdog_err), 32'd1);
    m_readdatavalid = 1'b1;
    tick();
    m_readdatavalid = 1'b0;
    tick();
    chk("wd_late_dropped", 32'(s_readdatavalid), 32'h0);
    idle_wait(GAP + 2);
    chk("wd_err_sticky", 32'(wdog_err), 32'd1);
    rst = 1'b1;
    tick();
    chk("wd_err_cleared", 32'(wdog_err), 32'd0);
    rst = 1'b0;
    tick();
`else
    chk("wd_err_tied", 32'(wdog_err), 32'd0);
`endif

    chk("sb_drained", 32'(sb.size()), 32'd0);
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
